// File: rtl/mem_wait_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_sram_if
// Brief    : val/wait/type request bus between a processor memory port and
//            a fixed-latency data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_wait_sram_if;
    logic        mem_val;
    logic        mem_wait;
    logic        mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_val,
        output mem_type,
        output mem_addr,
        output mem_wdata,
        input  mem_wait,
        input  mem_rdata
    );

    modport slave (
        input  mem_val,
        input  mem_type,
        input  mem_addr,
        input  mem_wdata,
        output mem_wait,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_wait_sram.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_sram
// Brief    : Word-addressed single-port data memory with a fixed access
//            latency and saturating read/write completion counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_sram #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_wait_sram_if.slave   bus,
    output logic [15:0]      num_reads,
    output logic [15:0]      num_writes
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] num_reads_q, num_reads_d;
    logic [15:0] num_writes_q, num_writes_d;

    logic          done;
    logic          wait_o;
    logic          rd_done;
    logic          wr_done;
    logic [AW-1:0] idx;
    logic [31:0]   mem_array [DEPTH];

    // Upper address bits alias and the byte offset is don't-care.
    logic [31-AW:0] unused_addr_bits;
    assign unused_addr_bits = {bus.mem_addr[31:2+AW], bus.mem_addr[1:0]};

    assign idx = bus.mem_addr[2 +: AW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_o  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_val) begin
                    if (LATENCY == 0) begin
                        done = 1'b1;
                    end else begin
                        wait_o  = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    wait_o = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    done    = bus.mem_val;
                    state_d = ST_IDLE;
                end
                // A requester dropping val mid-access abandons it entirely.
                if (!bus.mem_val) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign rd_done = done & ~bus.mem_type;
    assign wr_done = done &  bus.mem_type;

    always_comb begin
        num_reads_d  = num_reads_q;
        num_writes_d = num_writes_q;
        if (rd_done && (num_reads_q != CNT_MAX)) begin
            num_reads_d = num_reads_q + 16'd1;
        end
        if (wr_done && (num_writes_q != CNT_MAX)) begin
            num_writes_d = num_writes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            num_reads_q  <= 16'd0;
            num_writes_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            num_reads_q  <= num_reads_d;
            num_writes_q <= num_writes_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_done) begin
            mem_array[idx] <= bus.mem_wdata;
        end
    end

    assign bus.mem_wait  = wait_o;
    assign bus.mem_rdata = rd_done ? mem_array[idx] : 32'd0;
    assign num_reads     = num_reads_q;
    assign num_writes    = num_writes_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wait_sram
// Brief    : Self-checking bench for mem_wait_sram at latencies 2, 0 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wait_sram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic [15:0] nr_a, nw_a, nr_b, nw_b, nr_c, nw_c;

    mem_wait_sram_if if_a ();
    mem_wait_sram_if if_b ();
    mem_wait_sram_if if_c ();

    mem_wait_sram #(.DEPTH(256), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst_a), .bus(if_a), .num_reads(nr_a), .num_writes(nw_a));
    mem_wait_sram #(.DEPTH(256), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst_b), .bus(if_b), .num_reads(nr_b), .num_writes(nw_b));
    mem_wait_sram #(.DEPTH(256), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst_c), .bus(if_c), .num_reads(nr_c), .num_writes(nw_c));

    int checks = 0;
    int errors = 0;

    // Reference model: per-DUT word store plus completion counts.
    int          lat [3] = '{2, 0, 3};
    logic [31:0] mdl    [3][256];
    bit          mvalid [3][256];
    int          mr [3];
    int          mw [3];

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic get_wait(input int d);
        case (d)
            0:       return if_a.mem_wait;
            1:       return if_b.mem_wait;
            default: return if_c.mem_wait;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        case (d)
            0:       return if_a.mem_rdata;
            1:       return if_b.mem_rdata;
            default: return if_c.mem_rdata;
        endcase
    endfunction

    function automatic logic [15:0] get_nr(input int d);
        case (d)
            0:       return nr_a;
            1:       return nr_b;
            default: return nr_c;
        endcase
    endfunction

    function automatic logic [15:0] get_nw(input int d);
        case (d)
            0:       return nw_a;
            1:       return nw_b;
            default: return nw_c;
        endcase
    endfunction

    task automatic set_req(input int d, input logic v, input logic t,
                           input logic [31:0] a, input logic [31:0] w);
        case (d)
            0: begin if_a.mem_val = v; if_a.mem_type = t; if_a.mem_addr = a; if_a.mem_wdata = w; end
            1: begin if_b.mem_val = v; if_b.mem_type = t; if_b.mem_addr = a; if_b.mem_wdata = w; end
            default: begin if_c.mem_val = v; if_c.mem_type = t; if_c.mem_addr = a; if_c.mem_wdata = w; end
        endcase
    endtask

    task automatic set_rst(input int d, input logic r);
        case (d)
            0:       rst_a = r;
            1:       rst_b = r;
            default: rst_c = r;
        endcase
    endtask

    // One full request held until completion; entered and left at posedge+1.
    // waits = -1 flags a request that never completed.
    task automatic access(input int d, input logic typ, input logic [31:0] addr,
                          input logic [31:0] wd, output int waits,
                          output logic [31:0] rd, output bit nz_while_wait);
        bit finished;
        waits = 0; rd = 32'd0; nz_while_wait = 1'b0; finished = 1'b0;
        set_req(d, 1'b1, typ, addr, wd);
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            if (get_wait(d) === 1'b1) begin
                waits++;
                if (get_rdata(d) !== 32'd0) nz_while_wait = 1'b1;
            end else begin
                rd = get_rdata(d);
                finished = 1'b1;
            end
            @(posedge clk); #1;
        end
        set_req(d, 1'b0, 1'b0, 32'd0, 32'd0);
        if (!finished) begin
            waits = -1;
        end else if (typ) begin
            mdl[d][addr[9:2]]    = wd;
            mvalid[d][addr[9:2]] = 1'b1;
            mw[d] = sat(mw[d] + 1);
        end else begin
            mr[d] = sat(mr[d] + 1);
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            set_req(d, 1'b0, 1'b0, 32'd0, 32'd0);
            set_rst(d, 1'b1);
            mr[d] = 0; mw[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) set_rst(d, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (get_wait(d) !== 1'b0 || get_rdata(d) !== 32'd0 ||
                get_nr(d) !== 16'd0 || get_nw(d) !== 16'd0) begin
                errors++;
                $display("FAIL reset dut%0d: wait=%b rdata=%h nr=%h nw=%h, required 0/0/0/0",
                         d, get_wait(d), get_rdata(d), get_nr(d), get_nw(d));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int w; logic [31:0] rd; bit nz;
        access(0, 1'b1, 32'h0000_2000, 32'h0000_00AB, w, rd, nz);
        checks++;
        if (w !== 2 || nz) begin
            errors++; $display("FAIL wr_wait: waits=%0d nz=%0d, required 2/0", w, nz);
        end
        access(0, 1'b0, 32'h0000_2000, 32'h0, w, rd, nz);
        checks++;
        if (w !== 2 || rd !== 32'h0000_00AB || nz) begin
            errors++; $display("FAIL rd_after_wr: waits=%0d rdata=%h, required 2/000000ab", w, rd);
        end
        checks++;
        if (get_nr(0) !== 16'(mr[0]) || get_nw(0) !== 16'(mw[0]) || mr[0] != 1 || mw[0] != 1) begin
            errors++; $display("FAIL counters_wr_rd: nr=%0d nw=%0d, required 1/1", get_nr(0), get_nw(0));
        end
    endtask

    task automatic test_zero_latency;
        int w; logic [31:0] rd; bit nz;
        access(1, 1'b1, 32'h4, 32'hDEAD_BEEF, w, rd, nz);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL lat0_wr_wait: waits=%0d, required 0", w); end
        access(1, 1'b0, 32'h4, 32'h0, w, rd, nz);
        checks++;
        if (w !== 0 || rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL lat0_rd: waits=%0d rdata=%h, required 0/deadbeef", w, rd);
        end
    endtask

    task automatic test_alias;
        int w; logic [31:0] rd; bit nz;
        access(0, 1'b1, 32'h0000_0008, 32'h1234_5678, w, rd, nz);
        access(0, 1'b0, 32'h0000_040B, 32'h0, w, rd, nz);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL alias: rdata=%h, required 12345678", rd);
        end
    endtask

    task automatic test_abort;
        int w; logic [31:0] rd; bit nz;
        access(2, 1'b1, 32'h10, 32'h11, w, rd, nz);
        checks++;
        if (w !== 3) begin errors++; $display("FAIL lat3_wait: waits=%0d, required 3", w); end
        set_req(2, 1'b1, 1'b1, 32'h10, 32'h55);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (get_wait(2) !== 1'b1) begin errors++; $display("FAIL abort_pre: wait=%b, required 1", get_wait(2)); end
            @(posedge clk); #1;
        end
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (get_wait(2) !== 1'b1) begin errors++; $display("FAIL abort_cycle: wait=%b, required 1", get_wait(2)); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (get_wait(2) !== 1'b0) begin errors++; $display("FAIL abort_idle: wait=%b, required 0", get_wait(2)); end
        @(posedge clk); #1;
        access(2, 1'b0, 32'h10, 32'h0, w, rd, nz);
        checks++;
        if (rd !== 32'h11 || w !== 3 || get_nw(2) !== 16'(mw[2])) begin
            errors++; $display("FAIL abort_result: rdata=%h waits=%0d nw=%0d, required 11/3/%0d", rd, w, get_nw(2), mw[2]);
        end
    endtask

    task automatic test_reset_mid;
        int w; logic [31:0] rd; bit nz;
        access(0, 1'b1, 32'h20, 32'h7, w, rd, nz);
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h99);
        repeat (2) begin @(posedge clk); #1; end
        set_rst(0, 1'b1);
        @(negedge clk);
        checks++;
        if (get_wait(0) !== 1'b0) begin errors++; $display("FAIL rst_mid_completion: wait=%b, required 0", get_wait(0)); end
        @(posedge clk); #1;
        set_rst(0, 1'b0);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mr[0] = 0; mw[0] = 0;
        checks++;
        if (get_nr(0) !== 16'd0 || get_nw(0) !== 16'd0) begin
            errors++; $display("FAIL rst_mid_counters: nr=%0d nw=%0d, required 0/0", get_nr(0), get_nw(0));
        end
        access(0, 1'b0, 32'h20, 32'h0, w, rd, nz);
        checks++;
        if (rd !== 32'h7 || w !== 2) begin
            errors++; $display("FAIL rst_mid_read: rdata=%h waits=%0d, required 00000007/2", rd, w);
        end
    endtask

    task automatic test_back_to_back;
        int comps = 0;
        int bad = 0;
        set_req(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (get_wait(0) === 1'b0) begin
                comps++;
                if (get_rdata(0) !== mdl[0][0]) bad++;
            end else if (get_rdata(0) !== 32'd0) begin
                bad++;
            end
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mr[0] = sat(mr[0] + 9 / (lat[0] + 1));
        checks++;
        if (comps !== 9 / (lat[0] + 1) || bad != 0) begin
            errors++; $display("FAIL b2b_completions: got %0d (bad data %0d), required 3", comps, bad);
        end
        checks++;
        if (get_nr(0) !== 16'(mr[0])) begin
            errors++; $display("FAIL b2b_count: nr=%0d, required %0d", get_nr(0), mr[0]);
        end
    endtask

    task automatic test_random;
        int w; logic [31:0] rd, exp, r, dat; bit nz; logic typ; logic [7:0] ix;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                r   = $urandom;
                dat = $urandom;
                typ = 1'($urandom_range(0, 1));
                ix  = 8'($urandom_range(0, 255));
                if (!typ) begin
                    for (int k = 0; k < 256 && !mvalid[d][ix]; k++) ix = ix + 8'd1;
                    if (!mvalid[d][ix]) typ = 1'b1;
                end
                exp = mdl[d][ix];
                access(d, typ, {r[31:10], ix, r[1:0]}, dat, w, rd, nz);
                checks++;
                if (w !== lat[d] || nz || (!typ && rd !== exp) || (typ && rd !== 32'd0)) begin
                    errors++;
                    $display("FAIL rand dut%0d op%0d: waits=%0d rdata=%h, required %0d/%h",
                             d, n, w, rd, lat[d], typ ? 32'd0 : exp);
                end
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            checks++;
            if (get_nr(d) !== 16'(mr[d]) || get_nw(d) !== 16'(mw[d])) begin
                errors++;
                $display("FAIL rand_counters dut%0d: nr=%0d nw=%0d, required %0d/%0d",
                         d, get_nr(d), get_nw(d), mr[d], mw[d]);
            end
        end
    endtask

    task automatic test_saturation;
        int seen_wait = 0;
        set_rst(1, 1'b1);
        @(posedge clk); #1;
        set_rst(1, 1'b0);
        mr[1] = 0; mw[1] = 0;
        set_req(1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int c = 0; c < 65534; c++) begin
            @(negedge clk);
            if (get_wait(1) !== 1'b0) seen_wait++;
            @(posedge clk);
        end
        #1;
        mr[1] = sat(mr[1] + 65534);
        checks++;
        if (get_nr(1) !== 16'(mr[1])) begin
            errors++; $display("FAIL sat_near: nr=%h, required %h", get_nr(1), 16'(mr[1]));
        end
        repeat (6) @(posedge clk);
        #1;
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        mr[1] = sat(mr[1] + 6);
        checks++;
        if (get_nr(1) !== 16'hFFFF || mr[1] != 65535) begin
            errors++; $display("FAIL sat_hold: nr=%h, required ffff", get_nr(1));
        end
        checks++;
        if (seen_wait != 0) begin
            errors++; $display("FAIL lat0_never_wait: wait seen %0d cycles, required 0", seen_wait);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) begin mdl[d][i] = 32'd0; mvalid[d][i] = 1'b0; end
        end
        test_reset();
        test_write_read();
        test_zero_latency();
        test_alias();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wait_sram.md
# mem_wait_sram

Single-ported, word-addressed data memory with a configurable fixed access latency, implementing the val/wait/type request protocol used by the single-cycle processor's `imem` and `dmem` ports. It sits directly downstream of the processor's memory port, replacing the zero-latency test memory so that processor stall logic is exercised under realistic multi-cycle accesses. It also keeps saturating read and write transaction counters for bench and debug visibility.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 2..4096.
- `LATENCY`, 2: wait cycles inserted per access; 0..15.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `mem_val` input 1: request valid; held with all request fields stable until `mem_wait` is low.
- `mem_wait` output 1: requester must stall and hold its request.
- `mem_type` input 1: 0 = read, 1 = write.
- `mem_addr` input 32: byte address. Bits [1:0] are ignored.
- `mem_wdata` input 32: write data.
- `mem_rdata` output 32: read data; valid only in the completion cycle of a read.
- `num_reads` output 16: completed reads; saturates at 16'hFFFF.
- `num_writes` output 16: completed writes; saturates at 16'hFFFF.

## Operation
- Word index is `mem_addr[2 +: log2(DEPTH)]`. Upper address bits are ignored, so addresses alias and wrap modulo `DEPTH*4`.
- Storage array is not reset; contents persist across `rst`.
- FSM states:
  - IDLE, the reset state.
  - WAIT, with a 4-bit down-counter `cnt`.
- IDLE, `mem_val`=0: `mem_wait`=0, no action.
- IDLE, `mem_val`=1, `LATENCY`=0: the access completes in this cycle and the FSM stays in IDLE.
- IDLE, `mem_val`=1, `LATENCY`>0: `mem_wait`=1, `cnt` <= `LATENCY`-1, next state WAIT.
- WAIT, `cnt`!=0: `mem_wait`=1, `cnt` <= `cnt`-1.
- WAIT, `cnt`=0: the access completes in this cycle, `mem_wait`=0, next state IDLE.
- Completion of a read:
  - `mem_rdata` = array[index], combinational.
  - `num_reads` increments at the clock edge.
- Completion of a write:
  - array[index] <= `mem_wdata` at the clock edge.
  - `num_writes` increments at the clock edge.
  - `mem_rdata` = 0.
- `mem_rdata` = 0 in every non-completion cycle.
- `mem_val` dropping while in WAIT is a protocol violation:
  - The access is aborted and the FSM returns to IDLE at the next edge.
  - No write occurs and no counter is updated.
  - `mem_wait` follows the WAIT rules in that cycle.
- Back-to-back requests: after a completion the FSM is in IDLE. A `mem_val` still high on the next cycle is treated as a new request and pays the full latency again.
- Counters saturate; a completion at 16'hFFFF leaves the value unchanged.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0.
  - `num_reads` = `num_writes` = 0.
  - `mem_wait` = 0 and `mem_rdata` = 0 while `mem_val` = 0.
- Reset asserted mid-access: at the next edge the FSM goes to IDLE and counters clear. No write commits on that edge, even if it is the completion cycle.
- Request accepted in cycle T:
  - `mem_wait`=1 during T..T+`LATENCY`-1.
  - `mem_wait`=0 at T+`LATENCY`; that is the completion cycle.
- Write data becomes visible to a read that begins at T+`LATENCY`+1 or later.
- Throughput: one access per `LATENCY`+1 cycles.
- `mem_wait` and `mem_rdata` are combinational from the FSM state, `cnt`, `mem_val`, `mem_type`, `mem_addr` and the array. There is no combinational path from `mem_wdata` to any output.

## Test plan
- Write then read, `LATENCY`=2:
  - Stimulus: write 0x0000_00AB to 0x2000 held for 3 cycles, then read 0x2000.
  - `mem_wait` is 1,1,0 for the write and again 1,1,0 for the read.
  - `mem_rdata`=0x0000_00AB in the read's third cycle.
  - `num_writes`=1, `num_reads`=1.
- Zero latency, `LATENCY`=0:
  - Stimulus: write 0xDEAD_BEEF to 0x4, then read 0x4 on the next cycle.
  - `mem_wait` is never 1.
  - `mem_rdata`=0xDEAD_BEEF in the read cycle.
- Aliasing and byte offset, `DEPTH`=256:
  - Stimulus: write 0x1234_5678 to 0x0000_0008, then read 0x0000_040B.
  - `mem_rdata`=0x1234_5678.
- Abort, `LATENCY`=3:
  - Stimulus: write 0x55 to 0x10, drop `mem_val` after 2 cycles, then read 0x10, which was previously 0x11.
  - The read returns 0x11 and `num_writes` is unchanged.
- Reset mid-access:
  - Stimulus: assert `rst` during the completion cycle of a write of 0x99 to 0x20, whose old value is 0x7.
  - After reset, FSM = IDLE, counters = 0, and a read of 0x20 returns 0x7.
- Back-to-back and saturation:
  - Stimulus: hold `mem_val`=1 for reads across 9 cycles with `LATENCY`=2.
  - Exactly 3 completions occur.
  - Counter preloaded near 16'hFFFF via a long run stops at 16'hFFFF.
